// File: rtl/wash_pkg.sv
// wash_pkg: shared states, motor codes, programme table and default durations.
package wash_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5,
    S_FAULT = 3'd6,
    S_ABORT = 3'd7
  } state_t;
  localparam logic [1:0] MOT_OFF  = 2'b00;
  localparam logic [1:0] MOT_AGIT = 2'b01;
  localparam logic [1:0] MOT_SPIN = 2'b10;
  localparam logic [7:0] WASH_T_DEF    = 8'd12;
  localparam logic [7:0] RINSE_T_DEF   = 8'd5;
  localparam logic [7:0] SPIN_T_DEF    = 8'd6;
  localparam logic [7:0] FILL_TMO_DEF  = 8'd30;
  localparam logic [7:0] DRAIN_TMO_DEF = 8'd20;
  // Returns {W,R,S}; unused codes fall back to the full programme.
  function automatic logic [2:0] plan_of(input logic [2:0] mode);
    return mode == 3'd1 ? 3'b110 :
           mode == 3'd2 ? 3'b100 :
           mode == 3'd3 ? 3'b011 :
           mode == 3'd4 ? 3'b010 :
           mode == 3'd5 ? 3'b001 : 3'b111;
  endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: 8-bit loadable down-counter with tick enable, freeze and zero flag.
module phase_timer (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick,
  input  logic       freeze,
  output logic [7:0] count,
  output logic       zero
);
  assign zero = count == 8'd0;
  // Load beats a concurrent tick so a fresh phase starts from its full value.
  always_ff @(posedge CLK) begin
    if (!RST_N) count <= 8'd0;
    else if (load) count <= load_val;
    else if (tick && !freeze && !zero) count <= count - 8'd1;
  end
endmodule

// File: rtl/wash_sched.sv
// wash_sched: washing-machine cycle sequencer with pause, abort and fault handling.
module wash_sched
  import wash_pkg::*;
#(
  parameter logic [7:0] WASH_T    = WASH_T_DEF,
  parameter logic [7:0] RINSE_T   = RINSE_T_DEF,
  parameter logic [7:0] SPIN_T    = SPIN_T_DEF,
  parameter logic [7:0] FILL_TMO  = FILL_TMO_DEF,
  parameter logic [7:0] DRAIN_TMO = DRAIN_TMO_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TICK,
  input  logic       START,
  input  logic       STOP,
  input  logic [2:0] MODE,
  input  logic       LEVEL_OK,
  input  logic       EMPTY,
  output logic       VALVE_IN,
  output logic       VALVE_OUT,
  output logic [1:0] MOTOR,
  output logic [2:0] PHASE,
  output logic       RUN,
  output logic       PAUSED,
  output logic [7:0] REMAIN,
  output logic       DONE,
  output logic       ALARM
);
  state_t st, st_n;
  logic pau, pau_n, seg, seg_n, fin, zero;
  logic [1:0] plan, plan_n;
  logic [2:0] p;
  logic [7:0] ld_val;
  assign p = plan_of(MODE);
  assign ld_val = st_n == S_FILL  ? FILL_TMO  :
                  st_n == S_WASH  ? WASH_T    :
                  st_n == S_RINSE ? RINSE_T   :
                  st_n == S_DRAIN ? DRAIN_TMO :
                  st_n == S_SPIN  ? SPIN_T    : 8'd0;
  phase_timer u_tmr (
    .CLK(CLK), .RST_N(RST_N), .load(st_n != st), .load_val(ld_val),
    .tick(TICK), .freeze(pau), .count(REMAIN), .zero(zero)
  );
  // seg marks whether the current fill/run/drain segment is the rinse one.
  always_comb begin
    st_n = st;
    pau_n = pau;
    seg_n = seg;
    plan_n = plan;
    fin = 1'b0;
    unique case (st)
      S_IDLE: if (START) begin
        plan_n = p[1:0];
        seg_n = !p[2];
        st_n = (p[2] | p[1]) ? S_FILL : S_SPIN;
      end
      S_FAULT: if (STOP) st_n = S_IDLE;
      S_ABORT: if (EMPTY) st_n = S_IDLE;
      default: if (STOP) begin
        st_n = S_ABORT;
        pau_n = 1'b0;
      end else if (START) pau_n = !pau;
      else if (!pau) begin
        unique case (st)
          S_FILL: st_n = LEVEL_OK ? (seg ? S_RINSE : S_WASH) : zero ? S_FAULT : S_FILL;
          S_WASH, S_RINSE: if (zero) st_n = S_DRAIN;
          S_DRAIN: if (EMPTY) begin
            if (!seg && plan[1]) begin
              st_n = S_FILL;
              seg_n = 1'b1;
            end else if (plan[0]) st_n = S_SPIN;
            else begin
              st_n = S_IDLE;
              fin = 1'b1;
            end
          end else if (zero) st_n = S_FAULT;
          S_SPIN: if (zero) begin
            st_n = S_IDLE;
            fin = 1'b1;
          end
          default: ;
        endcase
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      st <= S_IDLE;
      pau <= 1'b0;
      seg <= 1'b0;
      plan <= 2'b00;
      VALVE_IN <= 1'b0;
      VALVE_OUT <= 1'b0;
      MOTOR <= MOT_OFF;
      PHASE <= 3'd0;
      RUN <= 1'b0;
      PAUSED <= 1'b0;
      DONE <= 1'b0;
      ALARM <= 1'b0;
    end else begin
      st <= st_n;
      pau <= pau_n;
      seg <= seg_n;
      plan <= plan_n;
      VALVE_IN <= st_n == S_FILL && !pau_n;
      VALVE_OUT <= ((st_n == S_DRAIN || st_n == S_SPIN) && !pau_n) || st_n == S_ABORT;
      MOTOR <= pau_n ? MOT_OFF :
               (st_n == S_WASH || st_n == S_RINSE) ? MOT_AGIT :
               st_n == S_SPIN ? MOT_SPIN : MOT_OFF;
      PHASE <= st_n;
      RUN <= st_n inside {S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN} && !pau_n;
      PAUSED <= pau_n;
      DONE <= fin;
      ALARM <= st_n == S_FAULT;
    end
  end
endmodule

// File: tb/tb_wash_sched.sv
// tb_wash_sched: table-driven programme sequences plus directed pause/fault/abort/reset cases.
module tb_wash_sched;
  logic CLK, RST_N, TICK, START, STOP, LEVEL_OK, EMPTY;
  logic [2:0] MODE;
  logic VALVE_IN, VALVE_OUT, RUN, PAUSED, DONE, ALARM;
  logic [1:0] MOTOR;
  logic [2:0] PHASE;
  logic [7:0] REMAIN;
  int checks = 0;
  int failures = 0;

  wash_sched dut (
    .CLK(CLK), .RST_N(RST_N), .TICK(TICK), .START(START), .STOP(STOP), .MODE(MODE),
    .LEVEL_OK(LEVEL_OK), .EMPTY(EMPTY), .VALVE_IN(VALVE_IN), .VALVE_OUT(VALVE_OUT),
    .MOTOR(MOTOR), .PHASE(PHASE), .RUN(RUN), .PAUSED(PAUSED), .REMAIN(REMAIN),
    .DONE(DONE), .ALARM(ALARM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  mode;
    logic [23:0] seq;
    int          wt;
    int          rt;
    int          spt;
  } vec_t;
  vec_t tbl[8];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick();
    TICK = 1'b1;
    step();
    TICK = 1'b0;
    step();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {13'd0, VALVE_IN, VALVE_OUT, MOTOR, PHASE, RUN, PAUSED, REMAIN, DONE, ALARM};
  endfunction

  function automatic int entry_val(input logic [2:0] ph);
    return ph == 3'd1 ? 30 : ph == 3'd2 ? 12 : ph == 3'd3 ? 20 : ph == 3'd4 ? 5 : ph == 3'd5 ? 6 : 0;
  endfunction

  task automatic pulse_start(input logic [2:0] m);
    MODE = m;
    START = 1'b1;
    step();
    START = 1'b0;
    MODE = 3'd0;
  endtask

  initial begin
    logic [23:0] got;
    logic [2:0] prev;
    int dn, c, bad;
    int tk[8];
    tbl[0] = '{3'd0, 24'o12314350, 12, 5, 6};
    tbl[1] = '{3'd1, 24'o01231430, 12, 5, 0};
    tbl[2] = '{3'd2, 24'o00001230, 12, 0, 0};
    tbl[3] = '{3'd3, 24'o00014350, 0, 5, 6};
    tbl[4] = '{3'd4, 24'o00001430, 0, 5, 0};
    tbl[5] = '{3'd5, 24'o00000050, 0, 0, 6};
    tbl[6] = '{3'd6, 24'o12314350, 12, 5, 6};
    tbl[7] = '{3'd7, 24'o12314350, 12, 5, 6};
    RST_N = 1'b0; TICK = 1'b0; START = 1'b0; STOP = 1'b0;
    MODE = 3'd0; LEVEL_OK = 1'b0; EMPTY = 1'b0;
    step();
    step();
    chk("reset_outputs", outs(), 32'd0);
    RST_N = 1'b1;
    step();
    chk("idle_outputs", outs(), 32'd0);

    // Full programmes with sensors answering one cycle after the valves open.
    for (int v = 0; v < 8; v++) begin
      got = '0; dn = 0; c = 0; prev = 3'd0;
      for (int k = 0; k < 8; k++) tk[k] = 0;
      pulse_start(tbl[v].mode);
      do begin
        if (DONE) dn++;
        if (PHASE != prev) begin
          got = {got[20:0], PHASE};
          prev = PHASE;
          if (PHASE != 3'd0) chk($sformatf("m%0d_entry_remain_ph%0d", v, PHASE), REMAIN, entry_val(PHASE));
        end
        if (PHASE == 3'd0) break;
        LEVEL_OK = VALVE_IN;
        EMPTY = VALVE_OUT;
        TICK = c[0];
        if (TICK && REMAIN != 8'd0) tk[PHASE]++;
        step();
        c++;
      end while (c < 3000);
      TICK = 1'b0; LEVEL_OK = 1'b0; EMPTY = 1'b0;
      chk($sformatf("m%0d_finished", v), PHASE == 3'd0, 1);
      chk($sformatf("m%0d_sequence", v), got, tbl[v].seq);
      chk($sformatf("m%0d_done_pulses", v), dn, 1);
      chk($sformatf("m%0d_wash_ticks", v), tk[2], tbl[v].wt);
      chk($sformatf("m%0d_rinse_ticks", v), tk[4], tbl[v].rt);
      chk($sformatf("m%0d_spin_ticks", v), tk[5], tbl[v].spt);
      step();
      chk($sformatf("m%0d_done_one_cycle", v), DONE, 0);
    end

    // Pause in WASH at REMAIN=7, ten frozen ticks, then resume.
    pulse_start(3'd2);
    LEVEL_OK = 1'b1;
    step();
    LEVEL_OK = 1'b0;
    chk("pause_in_wash", PHASE, 3'd2);
    for (int k = 0; k < 5; k++) tick();
    chk("pause_pre_remain", REMAIN, 7);
    chk("pause_pre_motor", MOTOR, 2'b01);
    START = 1'b1;
    MODE = 3'd5;
    step();
    START = 1'b0;
    chk("pause_flags", {PAUSED, RUN, MOTOR}, 4'b1000);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (REMAIN != 8'd7 || PAUSED != 1'b1 || MOTOR != 2'b00 || VALVE_IN || VALVE_OUT || PHASE != 3'd2) bad++;
    end
    chk("pause_hold", bad, 0);
    START = 1'b1;
    step();
    START = 1'b0;
    MODE = 3'd0;
    chk("resume_state", {PAUSED, RUN, MOTOR, PHASE, REMAIN}, {1'b0, 1'b1, 2'b01, 3'd2, 8'd7});
    tick();
    chk("resume_count", REMAIN, 6);
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    chk("stop_wash_abort", {PHASE, VALVE_OUT, MOTOR}, {3'd7, 1'b1, 2'b00});
    EMPTY = 1'b1;
    step();
    EMPTY = 1'b0;
    chk("abort_to_idle", {PHASE, DONE}, {3'd0, 1'b0});

    // Fill timeout leads to FAULT; START ignored, STOP clears.
    pulse_start(3'd2);
    chk("fill_entry", REMAIN, 30);
    for (int k = 0; k < 29; k++) tick();
    chk("fill_before_tmo", {PHASE, REMAIN}, {3'd1, 8'd1});
    tick();
    chk("fill_fault", {PHASE, ALARM, REMAIN, VALVE_IN, RUN}, {3'd6, 1'b1, 8'd0, 1'b0, 1'b0});
    pulse_start(3'd0);
    chk("fault_ignores_start", {PHASE, ALARM}, {3'd6, 1'b1});
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    chk("fault_cleared", {PHASE, ALARM}, {3'd0, 1'b0});

    // Paused RINSE, then START+STOP together: STOP wins and clears PAUSED.
    pulse_start(3'd4);
    LEVEL_OK = 1'b1;
    step();
    LEVEL_OK = 1'b0;
    chk("rinse_entered", {PHASE, REMAIN}, {3'd4, 8'd5});
    START = 1'b1;
    step();
    chk("rinse_paused", PAUSED, 1);
    STOP = 1'b1;
    step();
    START = 1'b0;
    STOP = 1'b0;
    chk("stop_wins", {PHASE, VALVE_OUT, PAUSED, MOTOR, REMAIN}, {3'd7, 1'b1, 1'b0, 2'b00, 8'd0});
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (PHASE != 3'd7 || !VALVE_OUT || DONE) bad++;
    end
    chk("abort_hold", bad, 0);
    EMPTY = 1'b1;
    step();
    EMPTY = 1'b0;
    chk("abort_idle_no_done", {PHASE, DONE}, {3'd0, 1'b0});

    // Reset during SPIN overrides concurrent inputs.
    pulse_start(3'd5);
    chk("spin_direct", {PHASE, MOTOR, VALVE_OUT, REMAIN}, {3'd5, 2'b10, 1'b1, 8'd6});
    tick();
    tick();
    chk("spin_count", REMAIN, 4);
    RST_N = 1'b0; TICK = 1'b1; START = 1'b1; STOP = 1'b1;
    step();
    chk("reset_mid_spin", outs(), 32'd0);
    RST_N = 1'b1; TICK = 1'b0; START = 1'b0; STOP = 1'b0;
    step();
    chk("after_reset_idle", outs(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
